jtbubl_snd_comm: RTL and testbench



---
 rtl/jtbubl_snd_pkg.sv | 25 ++
 rtl/jtbubl_snd_stretch.sv | 37 +++
 rtl/jtbubl_snd_comm.sv | 189 ++++++++++++++++++
 tb/tb_jtbubl_snd_comm.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtbubl_snd_pkg.sv
// Shared constants and types for the sound-side mailbox of the main/sound CPU link.
package jtbubl_snd_pkg;

    localparam logic [15:0] WinBase = 16'hB000;

    // Register offsets inside the 4-byte mailbox window
    localparam logic [1:0] RegCmd     = 2'd0;
    localparam logic [1:0] RegStat    = 2'd1;  // read: status, write: NMI enable
    localparam logic [1:0] RegNmiDis  = 2'd2;
    localparam logic [1:0] RegPendClr = 2'd3;

    localparam logic [7:0] IdleByte = 8'hff;

    localparam int unsigned CntW = 8;

    typedef enum logic {
        StIdle,
        StPulse
    } nmi_state_e;

    function automatic logic [7:0] stat_byte(input logic pend, input logic flag);
        return {6'h3f, pend, flag};
    endfunction

endpackage

// File: rtl/jtbubl_snd_stretch.sv
// Down-counter pulse stretcher: load sets the count to W, then it decrements to zero.
module jtbubl_snd_stretch
    import jtbubl_snd_pkg::*;
#(
    parameter int unsigned W        = 32,
    parameter bit          RST_FULL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic zero
);

    localparam logic [CntW-1:0] LoadVal = CntW'(W);
    localparam logic [CntW-1:0] RstVal  = RST_FULL ? LoadVal : '0;

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LoadVal;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CntW'(1);
        end
        zero = (cnt_q == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= RstVal;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/jtbubl_snd_comm.sv
// Sound-side mailbox: command capture, reply latch, NMI generation and stretched CPU reset.
module jtbubl_snd_comm
    import jtbubl_snd_pkg::*;
#(
    parameter int unsigned NMI_W = 32,
    parameter int unsigned RST_W = 64
) (
    input  logic        clk24,
    input  logic        rst,
    input  logic [7:0]  snd_latch,
    input  logic        snd_stb,
    input  logic        snd_rstn,
    input  logic [15:0] snd_addr,
    input  logic [7:0]  snd_dout,
    input  logic        snd_mreq_n,
    input  logic        snd_rd_n,
    input  logic        snd_wr_n,
    output logic        comm_cs,
    output logic [7:0]  comm_dout,
    output logic [7:0]  main_latch,
    output logic        main_stb,
    output logic        snd_flag,
    output logic        snd_nmi_n,
    output logic        snd_cpu_rst
);

    logic       stb_q, stb_l_q;
    logic [7:0] latch_q;
    logic       rd_q, rd_l_q, wr_q, wr_l_q;
    logic [1:0] off_q;
    logic [7:0] dout_q;

    logic [7:0] cmd_q, cmd_d;
    logic [7:0] comm_dout_q, comm_dout_d;
    logic [7:0] main_latch_q, main_latch_d;
    logic       main_stb_q, main_stb_d;
    logic       flag_q, flag_d;
    logic       nmi_en_q, nmi_en_d;
    logic       nmi_pend_q, nmi_pend_d;
    logic       nmi_n_q, nmi_n_d;
    logic       cpu_rst_q, cpu_rst_d;
    nmi_state_e state_q, state_d;

    logic rd_now, wr_now;
    logic stb_ev, rd_ev, wr_ev;
    logic hold, nmi_start, nmi_zero, rst_zero;

    assign comm_cs = !snd_mreq_n && (snd_addr[15:2] == WinBase[15:2]);
    assign rd_now  = comm_cs && !snd_rd_n;
    assign wr_now  = comm_cs && !snd_wr_n;

    always_comb begin
        stb_ev = stb_q && !stb_l_q;
        rd_ev  = rd_q && !rd_l_q;
        wr_ev  = wr_q && !wr_l_q;
        // Sample snd_rstn directly so a mid-pulse reset request silences NMI on the next edge
        hold      = cpu_rst_q || !snd_rstn;
        nmi_start = (state_q == StIdle) && nmi_pend_q && nmi_en_q;

        // Read data is captured once at the start of the access and then held
        comm_dout_d = comm_dout_q;
        if (rd_now && !rd_q) begin
            case (snd_addr[1:0])
                RegCmd:  comm_dout_d = cmd_q;
                RegStat: comm_dout_d = stat_byte(nmi_pend_q, flag_q);
                default: comm_dout_d = IdleByte;
            endcase
        end

        cmd_d        = stb_ev ? latch_q : cmd_q;
        main_stb_d   = wr_ev && (off_q == RegCmd);
        main_latch_d = main_stb_d ? dout_q : main_latch_q;

        flag_d = flag_q;
        if (rd_ev && (off_q == RegCmd)) flag_d = 1'b0;
        if (stb_ev)                     flag_d = 1'b1;
        if (hold)                       flag_d = 1'b0;

        nmi_en_d = nmi_en_q;
        if (wr_ev && (off_q == RegStat))   nmi_en_d = 1'b1;
        if (wr_ev && (off_q == RegNmiDis)) nmi_en_d = 1'b0;
        if (hold)                          nmi_en_d = 1'b0;

        nmi_pend_d = nmi_pend_q;
        if (nmi_start)                      nmi_pend_d = 1'b0;
        if (wr_ev && (off_q == RegPendClr)) nmi_pend_d = 1'b0;
        if (stb_ev)                         nmi_pend_d = 1'b1;
        if (hold)                           nmi_pend_d = 1'b0;

        state_d = state_q;
        nmi_n_d = nmi_n_q;
        case (state_q)
            StIdle: begin
                if (nmi_start) begin
                    state_d = StPulse;
                    nmi_n_d = 1'b0;
                end
            end
            StPulse: begin
                if (nmi_zero) begin
                    state_d = StIdle;
                    nmi_n_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                nmi_n_d = 1'b1;
            end
        endcase
        if (hold) begin
            state_d = StIdle;
            nmi_n_d = 1'b1;
        end

        cpu_rst_d = !snd_rstn || !rst_zero;
    end

    always_ff @(posedge clk24) begin
        if (rst) begin
            stb_q        <= 1'b0;
            stb_l_q      <= 1'b0;
            latch_q      <= 8'h00;
            rd_q         <= 1'b0;
            rd_l_q       <= 1'b0;
            wr_q         <= 1'b0;
            wr_l_q       <= 1'b0;
            off_q        <= 2'd0;
            dout_q       <= 8'h00;
            cmd_q        <= 8'h00;
            comm_dout_q  <= 8'hff;
            main_latch_q <= 8'h00;
            main_stb_q   <= 1'b0;
            flag_q       <= 1'b0;
            nmi_en_q     <= 1'b0;
            nmi_pend_q   <= 1'b0;
            state_q      <= StIdle;
            nmi_n_q      <= 1'b1;
            cpu_rst_q    <= 1'b1;
        end else begin
            stb_q        <= snd_stb;
            stb_l_q      <= stb_q;
            latch_q      <= snd_latch;
            rd_q         <= rd_now;
            rd_l_q       <= rd_q;
            wr_q         <= wr_now;
            wr_l_q       <= wr_q;
            off_q        <= snd_addr[1:0];
            dout_q       <= snd_dout;
            cmd_q        <= cmd_d;
            comm_dout_q  <= comm_dout_d;
            main_latch_q <= main_latch_d;
            main_stb_q   <= main_stb_d;
            flag_q       <= flag_d;
            nmi_en_q     <= nmi_en_d;
            nmi_pend_q   <= nmi_pend_d;
            state_q      <= state_d;
            nmi_n_q      <= nmi_n_d;
            cpu_rst_q    <= cpu_rst_d;
        end
    end

    jtbubl_snd_stretch #(
        .W        (NMI_W - 1),
        .RST_FULL (1'b0)
    ) u_nmi_cnt (
        .clk  (clk24),
        .rst  (rst || hold),
        .load (nmi_start),
        .zero (nmi_zero)
    );

    jtbubl_snd_stretch #(
        .W        (RST_W),
        .RST_FULL (1'b1)
    ) u_rst_cnt (
        .clk  (clk24),
        .rst  (rst),
        .load (!snd_rstn),
        .zero (rst_zero)
    );

    assign comm_dout   = comm_dout_q;
    assign main_latch  = main_latch_q;
    assign main_stb    = main_stb_q;
    assign snd_flag    = flag_q;
    assign snd_nmi_n   = nmi_n_q;
    assign snd_cpu_rst = cpu_rst_q;

endmodule

// File: tb/tb_jtbubl_snd_comm.sv
// Directed bench for the sound-side mailbox; all inputs change and outputs are sampled on negedges.
module tb_jtbubl_snd_comm;

    logic        clk24 = 1'b0;
    logic        rst;
    logic [7:0]  snd_latch;
    logic        snd_stb;
    logic        snd_rstn;
    logic [15:0] snd_addr;
    logic [7:0]  snd_dout;
    logic        snd_mreq_n, snd_rd_n, snd_wr_n;
    logic        comm_cs;
    logic [7:0]  comm_dout, main_latch;
    logic        main_stb, snd_flag, snd_nmi_n, snd_cpu_rst;

    int checks = 0;
    int errors = 0;

    always #5 clk24 = ~clk24;

    jtbubl_snd_comm #(
        .NMI_W (32),
        .RST_W (64)
    ) dut (
        .clk24       (clk24),
        .rst         (rst),
        .snd_latch   (snd_latch),
        .snd_stb     (snd_stb),
        .snd_rstn    (snd_rstn),
        .snd_addr    (snd_addr),
        .snd_dout    (snd_dout),
        .snd_mreq_n  (snd_mreq_n),
        .snd_rd_n    (snd_rd_n),
        .snd_wr_n    (snd_wr_n),
        .comm_cs     (comm_cs),
        .comm_dout   (comm_dout),
        .main_latch  (main_latch),
        .main_stb    (main_stb),
        .snd_flag    (snd_flag),
        .snd_nmi_n   (snd_nmi_n),
        .snd_cpu_rst (snd_cpu_rst)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk24);
    endtask

    task automatic sread(input logic [15:0] a, output logic [7:0] d);
        snd_addr = a; snd_mreq_n = 1'b0; snd_rd_n = 1'b0;
        cyc(4);
        d = comm_dout;
        snd_mreq_n = 1'b1; snd_rd_n = 1'b1;
        cyc(2);
    endtask

    task automatic swrite(input logic [15:0] a, input logic [7:0] v);
        snd_addr = a; snd_dout = v; snd_mreq_n = 1'b0; snd_wr_n = 1'b0;
        cyc(3);
        snd_mreq_n = 1'b1; snd_wr_n = 1'b1;
        cyc(2);
    endtask

    task automatic send_cmd(input logic [7:0] v);
        snd_latch = v; snd_stb = 1'b1;
        cyc(2);
        snd_stb = 1'b0;
        cyc(1);
    endtask

    task automatic count_low(output int len);
        len = 0;
        while (!snd_nmi_n && len < 300) begin
            len++;
            cyc(1);
        end
    endtask

    task automatic count_rst(output int n);
        n = 0;
        while (snd_cpu_rst && n < 300) begin
            n++;
            cyc(1);
        end
    endtask

    task automatic lows_over(input int n, output int lows);
        lows = 0;
        for (int i = 0; i < n; i++) begin
            cyc(1);
            if (!snd_nmi_n) lows++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] d;
        int         n, hi, first, prev, nruns, fall2, rise1;
        int         rl[2];
        logic       trace[120];

        rst = 1'b1; snd_rstn = 1'b0; snd_stb = 1'b0; snd_latch = 8'h00;
        snd_addr = 16'h0000; snd_dout = 8'h00;
        snd_mreq_n = 1'b1; snd_rd_n = 1'b1; snd_wr_n = 1'b1;
        cyc(4);
        check("rst_comm_dout", 32'(comm_dout), 32'hff);
        check("rst_main_latch", 32'(main_latch), 32'h00);
        check("rst_main_stb", 32'(main_stb), 32'h0);
        check("rst_flag", 32'(snd_flag), 32'h0);
        check("rst_nmi_n", 32'(snd_nmi_n), 32'h1);
        check("rst_cpu_rst", 32'(snd_cpu_rst), 32'h1);
        rst = 1'b0;
        cyc(3);
        check("rstn_held", 32'(snd_cpu_rst), 32'h1);
        snd_rstn = 1'b1;
        count_rst(n);
        check("rst_release_len", 32'(n), 32'd65);
        check("post_rst_nmi_n", 32'(snd_nmi_n), 32'h1);
        check("post_rst_flag", 32'(snd_flag), 32'h0);

        // Window decode boundaries
        snd_addr = 16'hB003; snd_mreq_n = 1'b0; #1;
        check("cs_b003", 32'(comm_cs), 32'h1);
        snd_addr = 16'hB004; #1;
        check("cs_b004", 32'(comm_cs), 32'h0);
        snd_addr = 16'hAFFF; #1;
        check("cs_afff", 32'(comm_cs), 32'h0);
        snd_addr = 16'hB000; snd_mreq_n = 1'b1; #1;
        check("cs_no_mreq", 32'(comm_cs), 32'h0);
        cyc(1);

        // Enabled NMI, command 5A
        swrite(16'hB001, 8'h00);
        snd_latch = 8'h5A; snd_stb = 1'b1;
        cyc(1);
        check("flag_edge0", 32'(snd_flag), 32'h0);
        cyc(1);
        check("flag_edge1", 32'(snd_flag), 32'h1);
        check("nmi_edge1", 32'(snd_nmi_n), 32'h1);
        snd_stb = 1'b0;
        cyc(1);
        check("nmi_fall", 32'(snd_nmi_n), 32'h0);
        count_low(n);
        check("nmi_width", 32'(n), 32'd32);
        sread(16'hB000, d);
        check("read_cmd_5a", 32'(d), 32'h5A);
        check("flag_cleared", 32'(snd_flag), 32'h0);

        // Disabled NMI, command 11, then enable
        swrite(16'hB002, 8'h00);
        send_cmd(8'h11);
        lows_over(40, n);
        check("no_pulse_dis", 32'(n), 32'd0);
        sread(16'hB001, d);
        check("stat_pend_flag", 32'(d), 32'hFF);
        check("stat_keeps_flag", 32'(snd_flag), 32'h1);
        sread(16'hB002, d);
        check("read_off2", 32'(d), 32'hFF);
        snd_addr = 16'hB001; snd_mreq_n = 1'b0; snd_wr_n = 1'b0;
        cyc(1);
        check("en_lat0", 32'(snd_nmi_n), 32'h1);
        cyc(1);
        check("en_lat1", 32'(snd_nmi_n), 32'h1);
        cyc(1);
        check("en_lat2", 32'(snd_nmi_n), 32'h0);
        snd_mreq_n = 1'b1; snd_wr_n = 1'b1;
        count_low(n);
        check("en_pulse_width", 32'(n), 32'd32);
        sread(16'hB000, d);
        check("read_cmd_11", 32'(d), 32'h11);

        // Reply write with a 3-cycle strobe
        check("main_latch_pre", 32'(main_latch), 32'h00);
        snd_addr = 16'hB000; snd_dout = 8'hC3; snd_mreq_n = 1'b0; snd_wr_n = 1'b0;
        hi = 0; first = -1;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            if (main_stb) begin
                hi++;
                if (first < 0) first = i;
            end
            if (i == 2) begin
                snd_mreq_n = 1'b1; snd_wr_n = 1'b1;
            end
        end
        check("main_stb_len", 32'(hi), 32'd1);
        check("main_stb_pos", 32'(first), 32'd1);
        check("main_latch_c3", 32'(main_latch), 32'hC3);

        // Command edge coinciding with a read of offset 0
        swrite(16'hB002, 8'h00);
        send_cmd(8'h22);
        snd_latch = 8'h33; snd_stb = 1'b1;
        snd_addr = 16'hB000; snd_mreq_n = 1'b0; snd_rd_n = 1'b0;
        cyc(3);
        check("same_cyc_old_cmd", 32'(comm_dout), 32'h22);
        check("same_cyc_flag", 32'(snd_flag), 32'h1);
        snd_stb = 1'b0;
        cyc(1);
        snd_mreq_n = 1'b1; snd_rd_n = 1'b1;
        cyc(2);
        sread(16'hB000, d);
        check("read_cmd_33", 32'(d), 32'h33);
        check("flag_clr_33", 32'(snd_flag), 32'h0);
        swrite(16'hB003, 8'h00);
        swrite(16'hB001, 8'h00);
        lows_over(6, n);
        check("pend_clr_no_pulse", 32'(n), 32'd0);

        // Second command arriving mid-pulse
        snd_latch = 8'h44; snd_stb = 1'b1;
        for (int i = 0; i < 120; i++) begin
            cyc(1);
            trace[i] = snd_nmi_n;
            if (i == 1) snd_stb = 1'b0;
            if (i == 10) begin
                snd_latch = 8'h55; snd_stb = 1'b1;
            end
            if (i == 12) snd_stb = 1'b0;
        end
        nruns = 0; prev = 1; rl[0] = 0; rl[1] = 0; fall2 = -1; rise1 = -1; first = -1;
        for (int i = 0; i < 120; i++) begin
            if (!trace[i]) begin
                if (prev == 1) begin
                    nruns++;
                    if (nruns == 1) first = i;
                    if (nruns == 2) fall2 = i;
                end
                if (nruns == 1) rl[0]++;
                if (nruns == 2) rl[1]++;
            end else if (prev == 0 && nruns == 1) begin
                rise1 = i;
            end
            prev = trace[i] ? 1 : 0;
        end
        check("two_pulses", 32'(nruns), 32'd2);
        check("p1_start", 32'(first), 32'd2);
        check("p1_width", 32'(rl[0]), 32'd32);
        check("p2_width", 32'(rl[1]), 32'd32);
        check("pulse_gap", 32'(fall2 - rise1), 32'd1);

        // Sound reset request mid-pulse
        snd_latch = 8'h66; snd_stb = 1'b1;
        cyc(2);
        snd_stb = 1'b0;
        cyc(5);
        check("pulse3_on", 32'(snd_nmi_n), 32'h0);
        snd_rstn = 1'b0;
        cyc(1);
        check("rstn_nmi_n", 32'(snd_nmi_n), 32'h1);
        check("rstn_flag", 32'(snd_flag), 32'h0);
        check("rstn_cpu_rst", 32'(snd_cpu_rst), 32'h1);
        check("rstn_main_latch", 32'(main_latch), 32'hC3);
        cyc(3);
        snd_rstn = 1'b1;
        count_rst(n);
        check("rst_release_len2", 32'(n), 32'd65);
        sread(16'hB000, d);
        check("cmd_kept", 32'(d), 32'h66);
        send_cmd(8'h77);
        lows_over(40, n);
        check("en_cleared", 32'(n), 32'd0);
        sread(16'hB001, d);
        check("stat_after_rstn", 32'(d), 32'hFF);

        // Synchronous reset in the middle of a pulse
        swrite(16'hB001, 8'h00);
        cyc(2);
        check("pulse4_on", 32'(snd_nmi_n), 32'h0);
        rst = 1'b1;
        cyc(1);
        check("rst_mid_nmi_n", 32'(snd_nmi_n), 32'h1);
        check("rst_mid_cpu_rst", 32'(snd_cpu_rst), 32'h1);
        rst = 1'b0;
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
